// File: rtl/count_monitor.sv
// count_monitor
//
// Receive-side checker for a WIDTH-bit up/down counter bus. The bus may be
// asynchronous to clock, so it is synchronised, debounced (a value must be
// seen unchanged for STABLE_CYCLES synchronised samples) and then each
// accepted transition is classified as an up step, a down step or an
// illegal skip.
//
// Ports:
//   clock       system clock, rising edge
//   rst         asynchronous active-high reset
//   count_in    observed counter bus (asynchronous to clock)
//   clear       synchronous clear of err_skip, wrap_count and err_count
//   value       last accepted count
//   dir_up      direction of the last legal step (1 = up, 0 = down)
//   dir_valid   dir_up is meaningful
//   step        one-cycle pulse per legal step
//   wrap        one-cycle pulse on a legal wrap (max->0 up, 0->max down)
//   err_skip    sticky flag: an illegal transition has been seen
//   wrap_count  saturating count of wraps
//   err_count   saturating count of illegal transitions
//   stalled     no accepted change for TIMEOUT cycles while tracking
module count_monitor #(
    parameter int WIDTH         = 6,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 50_000_000,
    parameter int STAT_W        = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              clear,
    output logic [WIDTH-1:0]  value,
    output logic              dir_up,
    output logic              dir_valid,
    output logic              step,
    output logic              wrap,
    output logic              err_skip,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] err_count,
    output logic              stalled
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0]  MAX_VAL     = '1;
    localparam logic [WIDTH-1:0]  ONE_VAL     = WIDTH'(1);
    localparam logic [STAT_W-1:0] STAT_MAX    = '1;
    localparam logic [STAB_W-1:0] STAB_TARGET = STAB_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LIMIT   = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser. fill_reg marks how far valid post-reset data has
    // travelled down the chain, so the reset contents of the chain are
    // never mistaken for a real bus sample.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]       sync_reg [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_reg;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
            fill_reg <= '0;
        end else begin
            sync_reg[0] <= count_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    logic [WIDTH-1:0] sync_out;
    logic             sync_valid;

    assign sync_out   = sync_reg[SYNC_STAGES-1];
    assign sync_valid = fill_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Candidate / stability tracking. Acceptance is decided from the
    // next-cycle stability count so that a stable value is accepted on the
    // very edge its count reaches STABLE_CYCLES.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  cand_reg,  cand_next;
    logic [STAB_W-1:0] stab_reg,  stab_next;

    always_comb begin
        cand_next = cand_reg;
        stab_next = stab_reg;
        if (sync_valid) begin
            if (sync_out != cand_reg) begin
                cand_next = sync_out;
                stab_next = STAB_W'(1);
            end else if (stab_reg != STAB_TARGET) begin
                stab_next = stab_reg + STAB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor state and outputs
    // ------------------------------------------------------------------
    state_t            state_reg,      state_next;
    logic [WIDTH-1:0]  value_reg,      value_next;
    logic              dir_up_reg,     dir_up_next;
    logic              dir_valid_reg,  dir_valid_next;
    logic              step_reg,       step_next;
    logic              wrap_reg,       wrap_next;
    logic              err_skip_reg,   err_skip_next;
    logic [STAT_W-1:0] wrap_count_reg, wrap_count_next;
    logic [STAT_W-1:0] err_count_reg,  err_count_next;
    logic              stalled_reg,    stalled_next;
    logic [TMO_W-1:0]  tmo_reg,        tmo_next;

    logic             accept;
    logic [WIDTH-1:0] delta;

    // IDLE accepts any stable value; afterwards only a real change counts.
    assign accept = (stab_next == STAB_TARGET) &&
                    ((state_reg == IDLE) || (cand_next != value_reg));
    assign delta  = cand_next - value_reg;

    always_comb begin
        state_next      = state_reg;
        value_next      = value_reg;
        dir_up_next     = dir_up_reg;
        dir_valid_next  = dir_valid_reg;
        step_next       = 1'b0;
        wrap_next       = 1'b0;
        err_skip_next   = err_skip_reg;
        wrap_count_next = wrap_count_reg;
        err_count_next  = err_count_reg;
        stalled_next    = stalled_reg;
        tmo_next        = tmo_reg;

        if (accept) begin
            tmo_next   = '0;
            value_next = cand_next;
            case (state_reg)
                IDLE: begin
                    state_next = TRACK;
                end
                TRACK, STALL: begin
                    state_next   = TRACK;
                    stalled_next = 1'b0;
                    if (delta == ONE_VAL) begin
                        step_next      = 1'b1;
                        dir_up_next    = 1'b1;
                        dir_valid_next = 1'b1;
                        wrap_next      = (cand_next == '0);
                    end else if (delta == MAX_VAL) begin
                        step_next      = 1'b1;
                        dir_up_next    = 1'b0;
                        dir_valid_next = 1'b1;
                        wrap_next      = (cand_next == MAX_VAL);
                    end else begin
                        dir_valid_next = 1'b0;
                        err_skip_next  = 1'b1;
                        if (err_count_reg != STAT_MAX) begin
                            err_count_next = err_count_reg + STAT_W'(1);
                        end
                    end
                    if (wrap_next && (wrap_count_reg != STAT_MAX)) begin
                        wrap_count_next = wrap_count_reg + STAT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else begin
            // Counter holds at the limit so STALL stays put until a change.
            if (tmo_reg != TMO_LIMIT) begin
                tmo_next = tmo_reg + TMO_W'(1);
            end
            if ((state_reg == TRACK) && (tmo_next == TMO_LIMIT)) begin
                stalled_next = 1'b1;
                state_next   = STALL;
            end
        end

        // clear overrides any same-cycle statistics update; pulses still fire.
        if (clear) begin
            err_skip_next   = 1'b0;
            wrap_count_next = '0;
            err_count_next  = '0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cand_reg       <= '0;
            stab_reg       <= '0;
            state_reg      <= IDLE;
            value_reg      <= '0;
            dir_up_reg     <= 1'b0;
            dir_valid_reg  <= 1'b0;
            step_reg       <= 1'b0;
            wrap_reg       <= 1'b0;
            err_skip_reg   <= 1'b0;
            wrap_count_reg <= '0;
            err_count_reg  <= '0;
            stalled_reg    <= 1'b0;
            tmo_reg        <= '0;
        end else begin
            cand_reg       <= cand_next;
            stab_reg       <= stab_next;
            state_reg      <= state_next;
            value_reg      <= value_next;
            dir_up_reg     <= dir_up_next;
            dir_valid_reg  <= dir_valid_next;
            step_reg       <= step_next;
            wrap_reg       <= wrap_next;
            err_skip_reg   <= err_skip_next;
            wrap_count_reg <= wrap_count_next;
            err_count_reg  <= err_count_next;
            stalled_reg    <= stalled_next;
            tmo_reg        <= tmo_next;
        end
    end

    assign value      = value_reg;
    assign dir_up     = dir_up_reg;
    assign dir_valid  = dir_valid_reg;
    assign step       = step_reg;
    assign wrap       = wrap_reg;
    assign err_skip   = err_skip_reg;
    assign wrap_count = wrap_count_reg;
    assign err_count  = err_count_reg;
    assign stalled    = stalled_reg;

endmodule
